// File: rtl/regfile_wb_responder.sv
// Integer register file answering the write-back stage's write handshake.
// Two bypassed read ports and a per-register busy scoreboard for decode.
module regfile_wb_responder #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_enable,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            wr_complete,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_set_addr,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              latch_en;
    logic              commit;
    logic [AW-1:0]     lat_addr;
    logic [XLEN-1:0]   lat_data;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic              in_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_enable) begin
                    latch_en   = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                commit     = (lat_addr != '0);
                state_next = DONE;
            end
            DONE: begin
                if (!wr_enable) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wr_complete = (state == DONE);
    assign in_write    = (state == WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr <= '0;
            lat_data <= '0;
        end else if (latch_en) begin
            lat_addr <= wr_addr;
            lat_data <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[lat_addr] <= lat_data;
        end
    end

    // Set is applied after the commit clear so a newly issued producer keeps ownership.
    always_comb begin
        busy_next = busy;
        if (commit) begin
            busy_next[lat_addr] = 1'b0;
        end
        if (sb_set && (sb_set_addr != '0)) begin
            busy_next[sb_set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        rs1_busy = busy[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
        end else if (in_write && (lat_addr == rs1_addr)) begin
            rs1_data = lat_data;
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        rs2_busy = busy[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
        end else if (in_write && (lat_addr == rs2_addr)) begin
            rs2_data = lat_data;
            rs2_busy = 1'b0;
        end
    end

endmodule
